// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions and
// the occupancy states of the main/skid register pair.
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // EMPTY: nothing held; ONE: main valid; TWO: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag derivation from adder operands and result.
// Shared by the add path now and the subtract path later.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic [3:0]       o_flags
);

  // Only operand sign bits matter; the low bits are folded into a sink.
  logic w_unused;
  assign w_unused = ^{i_a[WIDTH-2:0], i_b[WIDTH-2:0]};

  assign o_flags[FLAG_N] = i_sum[WIDTH-1];
  assign o_flags[FLAG_Z] = (i_sum == '0);
  assign o_flags[FLAG_C] = i_cout;
  // Signed overflow: like-signed operands producing a differently-signed sum.
  assign o_flags[FLAG_V] = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                           (i_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 8-bit adder. A main output register
// plus one skid register give full throughput under backpressure while
// keeping in_ready a pure register output. Also counts signed overflows.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main_result;
  logic [3:0]       r_main_flags;
  logic [WIDTH-1:0] r_skid_result;
  logic [3:0]       r_skid_flags;
  logic [CNT_W-1:0] r_ovf_count;
  logic [3:0]       w_flags;
  logic             w_acc;
  logic             w_drn;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_sum   (in_sum),
    .i_cout  (in_cout),
    .o_flags (w_flags)
  );

  // The ready register is forced low while reset is asserted so no beat
  // can be accepted during reset, and reads 1 on the first cycle after.
  assign in_ready   = r_in_ready & ~rst;
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_result = r_main_result;
  assign out_flags  = r_main_flags;
  assign ovf_count  = r_ovf_count;

  assign w_acc = in_valid && in_ready;
  assign w_drn = out_valid && out_ready;

  // Next-state and register-load decode for the main/skid pair.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_drn) begin
          w_load_main = 1'b1;
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_drn) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_drn) begin
          w_skid_to_main = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register and registered in_ready (low only when skid is full).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Main output register: loaded from the input or from the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_result <= '0;
      r_main_flags  <= '0;
    end else if (w_load_main) begin
      r_main_result <= in_sum;
      r_main_flags  <= w_flags;
    end else if (w_skid_to_main) begin
      r_main_result <= r_skid_result;
      r_main_flags  <= r_skid_flags;
    end
  end

  // Skid payload register, captured when main is busy and not draining.
  // NOTE: the skid payload has no reset; it is only read after a load,
  // and its occupancy lives in r_state, which is reset.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_result <= in_sum;
      r_skid_flags  <= w_flags;
    end
  end

  // Saturating signed-overflow counter; clear wins but still counts
  // an overflow accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_count <= '0;
    end else if (ovf_clr) begin
      r_ovf_count <= CNT_W'(w_acc && w_flags[FLAG_V]);
    end else if (w_acc && w_flags[FLAG_V] && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic, compared against a queue-based behavioural model. A second
// instance with a 2-bit counter exercises counter saturation.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       out_ready;
  logic       ovf_clr;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] ovf_count;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [7:0] sat_out_result;
  logic [3:0] sat_out_flags;
  logic [1:0] sat_ovf_count;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  alu_result_stage #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_result(sat_out_result),
    .out_flags(sat_out_flags), .ovf_count(sat_ovf_count), .ovf_clr(ovf_clr)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
  } beat_t;

  beat_t q[$];
  int    m_cnt8;
  int    m_cnt2;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected result of adding a and b, flags from plain integer arithmetic.
  function automatic beat_t ref_beat(input int a, input int b);
    beat_t r;
    int s, s8, sa, sb, ss;
    s  = a + b;
    s8 = s % 256;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    ss = sa + sb;
    r.res = 8'(s8);
    r.flg = {s8 >= 128, s8 == 0, s > 255, (ss > 127) || (ss < -128)};
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, then compare all outputs at the next falling edge.
  task automatic cycle(input logic v, input int a, input int b,
                       input logic rdy, input logic clr, input logic r);
    logic  m_ready, acc, drn;
    beat_t bt;
    rst       = r;
    in_valid  = v;
    out_ready = rdy;
    ovf_clr   = clr;
    if (v) begin
      in_a = 8'(a);
      in_b = 8'(b);
      {in_cout, in_sum} = 9'(a + b);
    end else begin
      in_a    = 8'($urandom);
      in_b    = 8'($urandom);
      in_sum  = 8'($urandom);
      in_cout = 1'($urandom);
    end
    #1;
    m_ready = !r && (q.size() < 2);
    check("in_ready", in_ready, m_ready);
    check("sat_in_ready", sat_in_ready, m_ready);
    bt  = ref_beat(a, b);
    acc = v && m_ready;
    drn = (q.size() > 0) && rdy;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(bt);
      if (clr) begin
        m_cnt8 = (acc && bt.flg[0]) ? 1 : 0;
        m_cnt2 = m_cnt8;
      end else if (acc && bt.flg[0]) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    check("sat_out_valid", sat_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_result", out_result, q[0].res);
      check("out_flags", out_flags, q[0].flg);
    end
    check("ovf_count", ovf_count, m_cnt8);
    check("sat_ovf_count", sat_ovf_count, m_cnt2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_cnt8   = 0;
    m_cnt2   = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
    in_cout = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_out_result", out_result, 8'h00);
    check("rst_out_flags", out_flags, 4'h0);
    check("rst_out_valid", out_valid, 1'b0);

    // Basic add
    cycle(1'b1, 16, 16, 1'b1, 1'b0, 1'b0);
    check("add1_res", out_result, 8'h20);
    check("add1_flg", out_flags, 4'b0000);
    cycle(1'b1, 20, 4, 1'b1, 1'b0, 1'b0);
    check("add2_res", out_result, 8'h18);
    check("add2_flg", out_flags, 4'b0000);
    idle(1);

    // Signed overflow and zero/carry
    cycle(1'b1, 100, 50, 1'b1, 1'b0, 1'b0);
    check("ovf_res", out_result, 8'h96);
    check("ovf_flg", out_flags, 4'b1001);
    check("ovf_cnt", ovf_count, 8'd1);
    cycle(1'b1, 200, 56, 1'b1, 1'b0, 1'b0);
    check("zc_res", out_result, 8'h00);
    check("zc_flg", out_flags, 4'b0110);
    check("zc_cnt", ovf_count, 8'd1);
    idle(1);

    // Backpressure: fill main and skid, then drain in order
    cycle(1'b1, 25, 50, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 11, 34, 1'b0, 1'b0, 1'b0);
    check("bp_ready_low", in_ready, 1'b0);
    check("bp_hold", out_result, 8'h4B);
    cycle(1'b1, 16, 16, 1'b0, 1'b0, 1'b0);
    check("bp_still_hold", out_result, 8'h4B);
    cycle(1'b1, 16, 16, 1'b1, 1'b0, 1'b0);
    check("bp_drain2", out_result, 8'h2D);
    check("bp_ready_back", in_ready, 1'b1);
    cycle(1'b1, 16, 16, 1'b1, 1'b0, 1'b0);
    check("bp_drain3", out_result, 8'h20);
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("bp_empty", out_valid, 1'b0);

    // Counter saturation on the 2-bit instance
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 100, 50, 1'b1, 1'b0, 1'b0);
      check("sat_seq", sat_ovf_count, sat_exp[i]);
    end
    cycle(1'b1, 100, 50, 1'b1, 1'b1, 1'b0);
    check("sat_clr_v", sat_ovf_count, 2'd1);
    check("clr_v", ovf_count, 8'd1);
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("sat_clr", sat_ovf_count, 2'd0);
    idle(1);

    // Reset while full
    cycle(1'b1, 100, 50, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 120, 30, 1'b0, 1'b0, 1'b0);
    check("mid_full", in_ready, 1'b0);
    cycle(1'b1, 7, 8, 1'b0, 1'b0, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_cnt", ovf_count, 8'd0);
    check("mid_rst_ready", in_ready, 1'b0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    check("mid_no_stale", out_valid, 1'b0);
    idle(2);

    // Streaming: accept and drain every cycle
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 40 + i, 1, 1'b1, 1'b0, 1'b0);
      check("stream_res", out_result, 8'(41 + i));
      check("stream_ready", in_ready, 1'b1);
    end
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(3, 0) != 0), int'($urandom_range(255, 0)),
            int'($urandom_range(255, 0)), ($urandom_range(9, 0) < 7),
            ($urandom_range(31, 0) == 0), ($urandom_range(99, 0) == 0));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
